// File: rtl/bram_fill_seq_pkg.sv
// Shared definitions for the BRAM capture sequencer: state encoding,
// frame counter width and a saturating increment helper.
package bram_fill_seq_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned FRAME_CNT_W = 16;

  localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] S_FILL     = 3'd1;
  localparam logic [STATE_W-1:0] S_WRITE    = 3'd2;
  localparam logic [STATE_W-1:0] S_CLEAR    = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE     = 3'd4;
  localparam logic [STATE_W-1:0] S_READBACK = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = S_IDLE,
    ST_FILL     = S_FILL,
    ST_WRITE    = S_WRITE,
    ST_CLEAR    = S_CLEAR,
    ST_DONE     = S_DONE,
    ST_READBACK = S_READBACK
  } state_t;

  // Frame counter increment that sticks at all-ones.
  function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
    return (v == '1) ? v : v + FRAME_CNT_W'(1);
  endfunction

endpackage

// File: rtl/bram_fill_seq_shift_frame_cnt.sv
// Modulo-WORDS_PER_FRAME shift counter; term_c flags the shift that
// completes a word.
module shift_frame_cnt #(
  parameter int unsigned WORDS_PER_FRAME = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic term_c
);

  localparam int unsigned CNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_FRAME - 1);

  logic [CNT_W-1:0] count;

  assign term_c = en && (count == LAST);

  // Count accepted shifts, wrapping to zero on the completing shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= term_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bram_fill_seq.sv
// BRAM capture sequencer: counts serial shifts, writes one BRAM word per
// frame, clears the shift register, advances/wraps the address and
// tracks start/stop/overflow.
// Optional feature macro: BRAM_FILL_SEQ_READBACK_EN adds a post-capture
// read sweep (bram_re/rd_valid ports) before DONE.
module bram_fill_seq
  import bram_fill_seq_pkg::*;
#(
  parameter int unsigned WORDS_PER_FRAME = 4,
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned DEPTH           = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_mode,
  input  logic                   din_valid,
  output logic                   sr_shift_en,
  output logic                   sr_clr,
  output logic                   bram_we,
  output logic [ADDR_W-1:0]      bram_addr,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
`ifdef BRAM_FILL_SEQ_READBACK_EN
  ,
  output logic                   bram_re,
  output logic                   rd_valid
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t state;
  logic   start_q;
  logic   start_rise_c;
  logic   stop_seen;
  logic   term_c;
  logic   cnt_clr_c;

  assign start_rise_c = start & ~start_q;
  assign sr_shift_en  = (state == ST_FILL) & din_valid;
  // The counter only holds meaningful state while filling a frame.
  assign cnt_clr_c    = (state != ST_FILL);

  shift_frame_cnt #(
    .WORDS_PER_FRAME(WORDS_PER_FRAME)
  ) u_shift_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (sr_shift_en),
    .clr    (cnt_clr_c),
    .term_c (term_c)
  );

  // Start level history for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sr_clr    <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      frame_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      stop_seen <= 1'b0;
`ifdef BRAM_FILL_SEQ_READBACK_EN
      bram_re   <= 1'b0;
      rd_valid  <= 1'b0;
`endif
    end else begin
      bram_we <= 1'b0;
      sr_clr  <= 1'b0;
`ifdef BRAM_FILL_SEQ_READBACK_EN
      rd_valid <= bram_re;
`endif
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_rise_c) begin
            state     <= ST_FILL;
            busy      <= 1'b1;
            done      <= 1'b0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
            bram_addr <= '0;
            stop_seen <= 1'b0;
          end
        end

        ST_FILL: begin
          // A completing shift wins over a simultaneous stop.
          if (term_c) begin
            state   <= ST_WRITE;
            bram_we <= 1'b1;
          end else if (stop) begin
            state     <= ST_CLEAR;
            sr_clr    <= 1'b1;
            stop_seen <= 1'b1;
          end
        end

        ST_WRITE: begin
          state     <= ST_CLEAR;
          sr_clr    <= 1'b1;
          frame_cnt <= sat_inc(frame_cnt);
          if (stop)      stop_seen <= 1'b1;
          if (din_valid) overflow  <= 1'b1;
        end

        ST_CLEAR: begin
          if (din_valid) overflow <= 1'b1;
          if (stop_seen) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            stop_seen <= 1'b0;
          end else if (bram_addr == LAST_ADDR) begin
            if (loop_mode) begin
              state     <= ST_FILL;
              bram_addr <= '0;
            end else begin
`ifdef BRAM_FILL_SEQ_READBACK_EN
              state     <= ST_READBACK;
              bram_addr <= '0;
              bram_re   <= 1'b1;
`else
              state     <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
`endif
            end
          end else begin
            state     <= ST_FILL;
            bram_addr <= bram_addr + ADDR_W'(1);
          end
        end

`ifdef BRAM_FILL_SEQ_READBACK_EN
        ST_READBACK: begin
          // bram_re low here means the last read's data is on rd_valid now.
          if (stop) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            bram_re <= 1'b0;
          end else if (bram_re) begin
            if (bram_addr == LAST_ADDR) begin
              bram_re <= 1'b0;
            end else begin
              bram_addr <= bram_addr + ADDR_W'(1);
            end
          end else begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
`endif

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_fill_seq.sv
// Directed bench for bram_fill_seq: a per-cycle vector table on a DEPTH=8
// instance plus multi-cycle sequences (full capture, loop wrap, async
// reset, optional readback) on DEPTH=8 and DEPTH=4 instances.
module tb_bram_fill_seq;
  import bram_fill_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic loop_mode = 1'b0;
  logic din_valid = 1'b0;

  logic                   a_shift, a_clr, a_we, a_busy, a_done, a_ovf;
  logic [3:0]             a_addr;
  logic [FRAME_CNT_W-1:0] a_fcnt;
  logic                   b_shift, b_clr, b_we, b_busy, b_done, b_ovf;
  logic [1:0]             b_addr;
  logic [FRAME_CNT_W-1:0] b_fcnt;
`ifdef BRAM_FILL_SEQ_READBACK_EN
  logic a_re, a_rv, b_re, b_rv;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_fill_seq #(.WORDS_PER_FRAME(4), .ADDR_W(4), .DEPTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_mode(loop_mode),
    .din_valid(din_valid), .sr_shift_en(a_shift), .sr_clr(a_clr), .bram_we(a_we),
    .bram_addr(a_addr), .frame_cnt(a_fcnt), .busy(a_busy), .done(a_done),
    .overflow(a_ovf)
`ifdef BRAM_FILL_SEQ_READBACK_EN
    , .bram_re(a_re), .rd_valid(a_rv)
`endif
  );

  bram_fill_seq #(.WORDS_PER_FRAME(4), .ADDR_W(2), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_mode(loop_mode),
    .din_valid(din_valid), .sr_shift_en(b_shift), .sr_clr(b_clr), .bram_we(b_we),
    .bram_addr(b_addr), .frame_cnt(b_fcnt), .busy(b_busy), .done(b_done),
    .overflow(b_ovf)
`ifdef BRAM_FILL_SEQ_READBACK_EN
    , .bram_re(b_re), .rd_valid(b_rv)
`endif
  );

  typedef struct {
    logic        start, stop, dv;
    logic        shift, we, clr, busy, done, ovf;
    logic [3:0]  addr;
    logic [15:0] fcnt;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic s, input logic p, input logic d,
                              input logic sh, input logic we, input logic cl,
                              input logic bu, input logic dn, input logic ov,
                              input logic [3:0] ad, input logic [15:0] fc);
    vec_t v;
    v.start = s; v.stop = p; v.dv = d;
    v.shift = sh; v.we = we; v.clr = cl; v.busy = bu; v.done = dn; v.ovf = ov;
    v.addr = ad; v.fcnt = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; stop = 1'b0; din_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int nwe;
    int last_cyc;
    logic pend_clr;
    logic saw_done;

    //         start stop dv | shift we clr busy done ovf addr fcnt
    tbl[0]  = mk(1, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1,  1, 0, 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1,  1, 0, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1,  1, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1,  1, 1, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 1,  0, 0, 1, 1, 0, 1, 0, 1);
    tbl[6]  = mk(0, 0, 0,  0, 0, 0, 1, 0, 1, 1, 1);
    tbl[7]  = mk(0, 0, 1,  1, 0, 0, 1, 0, 1, 1, 1);
    tbl[8]  = mk(0, 0, 1,  1, 0, 0, 1, 0, 1, 1, 1);
    tbl[9]  = mk(0, 1, 0,  0, 0, 1, 1, 0, 1, 1, 1);
    tbl[10] = mk(0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 1);
    tbl[11] = mk(0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 1);
    tbl[12] = mk(1, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 1,  1, 0, 0, 1, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 1,  1, 0, 0, 1, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 1,  1, 0, 0, 1, 0, 0, 0, 0);
    tbl[16] = mk(1, 0, 1,  1, 1, 0, 1, 0, 0, 0, 0);
    tbl[17] = mk(1, 1, 0,  0, 0, 1, 1, 0, 0, 0, 1);
    tbl[18] = mk(1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    tbl[19] = mk(1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    tbl[20] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    tbl[21] = mk(1, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0);
    tbl[22] = mk(1, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0);
    tbl[23] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) tick();
    chk("rst we",   32'(a_we),   32'(0));
    chk("rst clr",  32'(a_clr),  32'(0));
    chk("rst busy", 32'(a_busy), 32'(0));
    chk("rst done", 32'(a_done), 32'(0));
    chk("rst ovf",  32'(a_ovf),  32'(0));
    chk("rst addr", 32'(a_addr), 32'(0));
    chk("rst fcnt", 32'(a_fcnt), 32'(0));
    chk("rst b busy", 32'(b_busy), 32'(0));
    rst_n = 1'b1;
    tick();

    // Per-cycle vector table on the DEPTH=8 instance
    loop_mode = 1'b0;
    for (int i = 0; i < 24; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; din_valid = tbl[i].dv;
      #1;
      chk($sformatf("v%0d shift", i), 32'(a_shift), 32'(tbl[i].shift));
      tick();
      chk($sformatf("v%0d we", i),   32'(a_we),   32'(tbl[i].we));
      chk($sformatf("v%0d clr", i),  32'(a_clr),  32'(tbl[i].clr));
      chk($sformatf("v%0d busy", i), 32'(a_busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d done", i), 32'(a_done), 32'(tbl[i].done));
      chk($sformatf("v%0d ovf", i),  32'(a_ovf),  32'(tbl[i].ovf));
      chk($sformatf("v%0d addr", i), 32'(a_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d fcnt", i), 32'(a_fcnt), 32'(tbl[i].fcnt));
    end

    // Full capture, DEPTH=8, continuous valid, no loop
    do_reset();
    loop_mode = 1'b0; start = 1'b1; din_valid = 1'b1;
    nwe = 0; last_cyc = -1; pend_clr = 1'b0;
    for (int cyc = 0; cyc < 200 && !a_done; cyc++) begin
      tick();
      if (pend_clr) begin
        chk("A clr after we", 32'(a_clr), 32'(1));
        pend_clr = 1'b0;
      end
      if (a_we) begin
        chk($sformatf("A we%0d addr", nwe), 32'(a_addr), 32'(nwe));
        if (nwe > 0) chk($sformatf("A we%0d spacing", nwe), 32'(cyc - last_cyc), 32'(6));
        last_cyc = cyc;
        nwe++;
        pend_clr = 1'b1;
      end
    end
    chk("A we count", 32'(nwe),    32'(8));
    chk("A done",     32'(a_done), 32'(1));
    chk("A fcnt",     32'(a_fcnt), 32'(8));
    chk("A busy",     32'(a_busy), 32'(0));
    tick();
    chk("A done held", 32'(a_done), 32'(1));

    // Loop mode, DEPTH=4, ten frames
    do_reset();
    loop_mode = 1'b1; start = 1'b1; din_valid = 1'b1;
    nwe = 0; saw_done = 1'b0;
    for (int cyc = 0; cyc < 200 && nwe < 10; cyc++) begin
      tick();
      if (b_done) saw_done = 1'b1;
      if (b_we) begin
        chk($sformatf("B we%0d addr", nwe), 32'(b_addr), 32'(nwe % 4));
        nwe++;
      end
    end
    chk("B we count",  32'(nwe),      32'(10));
    chk("B no done",   32'(saw_done), 32'(0));
    chk("B busy",      32'(b_busy),   32'(1));
    stop = 1'b1;
    repeat (2) tick();
    chk("B stop in write busy", 32'(b_busy), 32'(0));
    chk("B stop addr held",     32'(b_addr), 32'(1));
    chk("B stop fcnt",          32'(b_fcnt), 32'(10));
    stop = 1'b0;

    // Asynchronous reset in the middle of a frame at address 5
    do_reset();
    loop_mode = 1'b0; start = 1'b1; din_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && !(a_addr == 4'd5 && a_busy); cyc++) tick();
    chk("C reached addr5", 32'(a_addr), 32'(5));
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("C rst we",    32'(a_we),    32'(0));
    chk("C rst clr",   32'(a_clr),   32'(0));
    chk("C rst busy",  32'(a_busy),  32'(0));
    chk("C rst ovf",   32'(a_ovf),   32'(0));
    chk("C rst addr",  32'(a_addr),  32'(0));
    chk("C rst fcnt",  32'(a_fcnt),  32'(0));
    chk("C rst shift", 32'(a_shift), 32'(0));
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    chk("C restart busy", 32'(a_busy), 32'(1));
    chk("C restart addr", 32'(a_addr), 32'(0));
    repeat (4) tick();
    chk("C first we",      32'(a_we),   32'(1));
    chk("C first we addr", 32'(a_addr), 32'(0));

`ifdef BRAM_FILL_SEQ_READBACK_EN
    // Readback sweep after the last write, DEPTH=4
    begin
      int rb;
      int rv;
      logic prev_re;
      do_reset();
      loop_mode = 1'b0; start = 1'b1; din_valid = 1'b1;
      rb = 0; rv = 0; prev_re = 1'b0;
      for (int cyc = 0; cyc < 200 && !b_done; cyc++) begin
        tick();
        if (b_rv) begin
          chk($sformatf("R rv%0d after re", rv), 32'(prev_re), 32'(1));
          rv++;
        end
        if (b_re) begin
          chk($sformatf("R re%0d addr", rb), 32'(b_addr), 32'(rb));
          rb++;
        end
        prev_re = b_re;
      end
      chk("R re count", 32'(rb),     32'(4));
      chk("R rv count", 32'(rv),     32'(4));
      chk("R done",     32'(b_done), 32'(1));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
